fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch controller for the 5-stage pipeline. It sits directly upstream of the F/D pipeline register and drives it with `{pc_plus_2, instruction}`. It owns the PC register and runs a request/acknowledge handshake to a variable-latency instruction memory. It also applies stall, flush/redirect and halt from the decode and writeback stages, and inserts NOP bubbles when no instruction is ready.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0000, encoding emitted on bubble cycles

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-high
- stall  in  1  decode hazard stall; hold the current instruction and PC
- flush  in  1  branch taken in decode; redirect to branch_target
- branch_target  in  16  redirect address, sampled when flush=1
- halt  in  1  HLT retired in writeback; stop fetching permanently
- imem_ack  in  1  memory returns data for the current request
- imem_rdata  in  16  instruction data, valid when imem_ack=1
- imem_req  out  1  request to instruction memory
- imem_addr  out  16  request address (= pc)
- pc  out  16  current PC register
- F_valid  out  1  F_out holds a real instruction this cycle
- F_out  out  32  {[31:16] pc+2, [15:0] instruction or NOP_INSTR}

## Operation
- **State machine.** States are FETCH, HOLD, DRAIN and HALTED. Reset state is FETCH.
- **FETCH.**
  - imem_req=1 and imem_addr=pc.
  - imem_ack with no stall and no flush: F_valid=1 and F_out={pc+2, imem_rdata} combinationally. pc<=pc+2. Stay in FETCH.
  - imem_ack with stall=1: capture imem_rdata into the hold register and go to HOLD. pc is unchanged.
  - No ack: F_valid=0 and F_out={pc+2, NOP_INSTR}.
- **HOLD.**
  - imem_req=0. F_valid=1 and F_out={pc+2, hold_reg}.
  - When stall=0: pc<=pc+2 and go to FETCH.
- **Flush (priority over stall).**
  - pc<=branch_target and F_valid=0 that cycle.
  - In FETCH without ack: the request is outstanding, so go to DRAIN.
  - In FETCH with ack, or in HOLD: discard the data and go to FETCH.
- **DRAIN.**
  - imem_req stays 1 at the old, already-latched address until imem_ack. F_valid=0.
  - On ack: discard the data and go to FETCH, which fetches the redirected pc.
  - Flush while in DRAIN: update pc to the new branch_target and stay in DRAIN.
- **Halt (highest priority).** From any state go to HALTED. In HALTED: imem_req=0, F_valid=0, pc frozen. Only reset exits HALTED.
- **Width rules.**
  - pc+2 is a 16-bit add that wraps modulo 2^16, so 16'hFFFE+2 gives 16'h0000.
  - branch_target bit 0 is forced to 0.
- **DRAIN address latch.** imem_addr in DRAIN comes from a latched copy of the pre-flush pc, not from pc.

## Timing
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, F_valid=0, F_out={RESET_PC+2, NOP_INSTR}, state=FETCH.
- imem_req rises in the first cycle after reset deasserts.
- Reset asserted mid-request abandons the request. The memory must tolerate the request dropping without an ack.
- Minimum latency is 1 cycle from request to F_valid, for an ack in the same cycle as the request. Memory latency N gives N bubbles.
- Back-to-back same-cycle acks sustain one instruction per cycle.
- The handshake is held: while imem_req=1 and no ack, imem_addr must not change.
- Simultaneous events:
  - halt+flush resolves as halt.
  - flush+stall resolves as flush.
  - ack+flush discards the data.
  - ack+halt discards the data.

## Structure
- Shared package `cpu_pkg` holds:
  - the fetch state enum;
  - the INSTR_W=16 and PC_W=16 constants;
  - the F_out field offsets ([31:16] for pc+2, [15:0] for the instruction);
  - the NOP encoding.
- The PC update logic (pc+2 / hold / redirect mux plus the register) forms one natural sub-module, `pc_reg`. The FSM, hold register and DRAIN address latch stay in `fetch_ctrl`.

## Test plan
- Reset, then memory with a same-cycle ack: imem_addr runs 0000, 0002, 0004 on consecutive cycles. F_valid=1 from the first post-reset cycle, and F_out[31:16] runs 0002, 0004, 0006.
- Ack delayed by 3 cycles: 3 bubble cycles with F_valid=0 and F_out[15:0]=NOP_INSTR. imem_addr stays 0000 throughout, then data appears with F_valid=1.
- stall=1 for 2 cycles coincident with an ack carrying 16'hA123: F_out={0002, A123} is held for 3 cycles, imem_req=0 in HOLD, and pc=0000 until the stall clears.
- flush with branch_target=0x0040 while a 2-cycle request to 0x0004 is outstanding: DRAIN holds imem_addr=0004 until the ack, the data is discarded (F_valid=0), and the next request goes to 0x0040.
- halt asserted together with flush: state becomes HALTED, imem_req=0, F_valid=0, and pc stays frozen (unchanged by flush) for 10+ cycles. Asserting rst_n returns pc to RESET_PC.
- pc=FFFE with an ack: F_out[31:16]=0000 and the next imem_addr=0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants, fetch FSM state type and F/D register field layout.
package cpu_pkg;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 16;
  localparam int unsigned FOUT_W  = PC_W + INSTR_W;

  localparam int unsigned FOUT_INSTR_LSB = 0;
  localparam int unsigned FOUT_PC_LSB    = INSTR_W;

  localparam logic [INSTR_W-1:0] NOP_ENC = 16'h0000;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN,
    HALTED
  } fetch_state_t;
endpackage

// File: rtl/pc_reg.sv
// Program counter register: redirect takes priority over sequential advance.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            redirect,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus_2
);

  // Wraps modulo 2^16 by construction of the 16-bit add.
  assign pc_plus_2 = pc + PC_W'(2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target;
    end else if (advance) begin
      pc <= pc_plus_2;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, handshakes with instruction memory
// and feeds {pc+2, instruction} to the F/D register, applying stall/flush/halt.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               halt,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  output logic [PC_W-1:0]    pc,
  output logic               F_valid,
  output logic [FOUT_W-1:0]  F_out
);

  fetch_state_t         state;
  logic [INSTR_W-1:0]   hold_reg;
  logic [PC_W-1:0]      drain_addr;
  logic [PC_W-1:0]      pc_plus_2;
  logic [PC_W-1:0]      target;
  logic [INSTR_W-1:0]   instr;
  logic                 advance;
  logic                 redirect;

  assign target = branch_target & ~PC_W'(1);

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst_n),
    .advance   (advance),
    .redirect  (redirect),
    .target    (target),
    .pc        (pc),
    .pc_plus_2 (pc_plus_2)
  );

  // rst_n is active-high; the request is masked while reset is held.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    F_valid   = 1'b0;
    instr     = NOP_INSTR;
    advance   = 1'b0;
    redirect  = flush && !halt && (state != HALTED);
    unique case (state)
      FETCH: begin
        imem_req = !rst_n;
        if (imem_ack && !flush && !halt && !rst_n) begin
          F_valid = 1'b1;
          instr   = imem_rdata;
          advance = !stall;
        end
      end
      HOLD: begin
        if (!flush && !halt) begin
          F_valid = 1'b1;
          instr   = hold_reg;
          advance = !stall;
        end
      end
      DRAIN: begin
        imem_req  = !rst_n;
        imem_addr = drain_addr;
      end
      default: ;
    endcase
    F_out = '0;
    F_out[FOUT_PC_LSB +: PC_W]       = pc_plus_2;
    F_out[FOUT_INSTR_LSB +: INSTR_W] = instr;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= FETCH;
      hold_reg   <= '0;
      drain_addr <= RESET_PC;
    end else if (halt) begin
      state <= HALTED;
    end else begin
      unique case (state)
        FETCH: begin
          if (flush) begin
            // Unacked request stays on the bus at the pre-redirect address.
            if (!imem_ack) begin
              state      <= DRAIN;
              drain_addr <= pc;
            end
          end else if (imem_ack && stall) begin
            state    <= HOLD;
            hold_reg <= imem_rdata;
          end
        end
        HOLD: begin
          if (flush || !stall) state <= FETCH;
        end
        DRAIN: begin
          if (imem_ack) state <= FETCH;
        end
        default: ;
      endcase
    end
  end

endmodule
